ar_sync_queue: RTL

// Single-clock AXI read-address (AR) request queue for XBar slave/master ports in one clock domain.

---
 rtl/axi_xbar_pkg.sv | 14 +
 rtl/fifo_ptr_ctrl.sv | 43 ++++
 rtl/ar_sync_queue.sv | 103 ++++++++++
 3 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar types: burst encoding and pointer sizing helper.
package axi_xbar_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy control with explicit wrap for non-power-of-2 depths.
module fifo_ptr_ctrl
  import axi_xbar_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ar_sync_queue.sv
// Single-clock AXI AR request queue with first-word fall-through.
// Optional empty-queue bypass when AR_SYNC_QUEUE_BYPASS_EN is defined.
module ar_sync_queue
  import axi_xbar_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 4,
  parameter int SIZE_WIDTH   = 3,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_WIDTH-1:0]        s_ARID,
  input  logic [ADDR_WIDTH-1:0]      s_ARADDR,
  input  logic [LEN_WIDTH-1:0]       s_ARLEN,
  input  logic [SIZE_WIDTH-1:0]      s_ARSIZE,
  input  logic [1:0]                 s_ARBURST,
  input  logic                       s_ARVALID,
  output logic                       s_ARREADY,
  output logic [ID_WIDTH-1:0]        m_ARID,
  output logic [ADDR_WIDTH-1:0]      m_ARADDR,
  output logic [LEN_WIDTH-1:0]       m_ARLEN,
  output logic [SIZE_WIDTH-1:0]      m_ARSIZE,
  output logic [1:0]                 m_ARBURST,
  output logic                       m_ARVALID,
  input  logic                       m_ARREADY,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    axi_burst_e            burst;
  } ar_req_t;

  ar_req_t          mem [DEPTH];
  ar_req_t          s_req;
  ar_req_t          head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  assign s_req = '{id: s_ARID, addr: s_ARADDR, len: s_ARLEN, size: s_ARSIZE,
                   burst: axi_burst_e'(s_ARBURST)};

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (wr_en),
    .pop    (rd_en),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (cnt),
    .full   (full),
    .empty  (empty)
  );

  // s_ARREADY depends only on rst and registered occupancy, never on m_ARREADY
  always_comb begin
    s_ARREADY = !rst && !full;
    rd_en     = !rst && !empty && m_ARREADY;
`ifdef AR_SYNC_QUEUE_BYPASS_EN
    if (empty) begin
      m_ARVALID = !rst && s_ARVALID;
      head      = s_req;
    end else begin
      m_ARVALID = !rst;
      head      = mem[rd_ptr];
    end
    wr_en = s_ARVALID && s_ARREADY && !(empty && m_ARREADY);
`else
    m_ARVALID = !rst && !empty;
    head      = mem[rd_ptr];
    wr_en     = s_ARVALID && s_ARREADY;
`endif
  end

  // Storage holds data only; it is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_req;
  end

  assign m_ARID      = head.id;
  assign m_ARADDR    = head.addr;
  assign m_ARLEN     = head.len;
  assign m_ARSIZE    = head.size;
  assign m_ARBURST   = head.burst;
  assign count       = rst ? '0 : cnt;
  assign almost_full = !rst && (cnt >= CNT_W'(AFULL_THRESH));

endmodule
